// File: rtl/cell_comm_pkg.sv
// Shared constants for the cell-controller packet format (RX decoder and TX builder).
package cell_comm_pkg;

    localparam logic [15:0] CELL_COMM_MAGIC = 16'hA5BE;
    localparam int unsigned PKT_WORDS       = 4;
    localparam int unsigned INVALID_BIT     = 31;
    localparam int unsigned CLIP_BIT        = 30;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_X     = 3'd1,
        ST_Y     = 3'd2,
        ST_S     = 3'd3,
        ST_DRAIN = 3'd4
    } cell_comm_state_t;

    // Magic in the top half, and every bit above the FOFB index must be zero.
    function automatic logic hdr_valid(input logic [31:0] word, input int unsigned idx_w);
        return (word[31:16] == CELL_COMM_MAGIC) && ((word[15:0] >> idx_w) == 16'h0000);
    endfunction

endpackage

// File: rtl/cell_comm_packet_decoder_sat_counter.sv
// Saturating event counter; clr with inc in the same cycle restarts the count at 1.
module cell_comm_sat_counter
    import cell_comm_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= inc ? COUNT_WIDTH'(1) : '0;
        end else if (inc && (value != '1)) begin
            value <= value + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cell_comm_packet_decoder.sv
// Aurora RX cell-controller packet decoder: parses header/X/Y/S, writes the BPM table, keeps stats.
// Optional macro CELL_COMM_DECODER_BITMAP_EN adds the per-FA-cycle seen bitmap and duplicate counter.
module cell_comm_packet_decoder
    import cell_comm_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FOFB_IDX_WIDTH = 9,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                      rxClk,
    input  logic                      rxAresetn,
    input  logic                      rxValid,
    input  logic                      rxLast,
    input  logic [DATA_WIDTH-1:0]     rxData,
    input  logic                      rxCRCvalid,
    input  logic                      rxCRCpass,
    input  logic                      rxFaStrobe,
    output logic                      wrEnable,
    output logic [FOFB_IDX_WIDTH-1:0] wrIndex,
    output logic [DATA_WIDTH-1:0]     wrX,
    output logic [DATA_WIDTH-1:0]     wrY,
    output logic [DATA_WIDTH-3:0]     wrS,
    output logic                      wrClip,
    output logic [COUNT_WIDTH-1:0]    goodCount,
    output logic [COUNT_WIDTH-1:0]    hdrErrCount,
    output logic [COUNT_WIDTH-1:0]    crcErrCount,
    output logic [COUNT_WIDTH-1:0]    shortErrCount,
    output logic [COUNT_WIDTH-1:0]    longErrCount,
    output logic [COUNT_WIDTH-1:0]    cycleCount
`ifdef CELL_COMM_DECODER_BITMAP_EN
    ,
    output logic [2**FOFB_IDX_WIDTH-1:0] rxSeenBitmap,
    output logic [COUNT_WIDTH-1:0]       dupErrCount
`endif
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    cell_comm_state_t          state;
    cell_comm_state_t          state_nxt;
    logic [IDLE_W-1:0]         idle_cnt;
    logic [FOFB_IDX_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0]     x_q;
    logic [DATA_WIDTH-1:0]     y_q;
    logic [COUNT_WIDTH-1:0]    tally;

    logic hdr_ok;
    logic crc_ok;
    logic timeout;
    logic commit;
    logic hdr_err;
    logic crc_err;
    logic short_err;
    logic long_err;

    assign hdr_ok  = hdr_valid(rxData, FOFB_IDX_WIDTH);
    assign crc_ok  = rxCRCvalid && rxCRCpass && !rxData[INVALID_BIT];
    assign timeout = !rxValid && (state != ST_HDR) && (idle_cnt == IDLE_MAX);

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        hdr_err   = 1'b0;
        crc_err   = 1'b0;
        short_err = 1'b0;
        long_err  = 1'b0;
        case (state)
            ST_HDR: begin
                if (rxValid) begin
                    if (!hdr_ok) hdr_err = 1'b1;
                    if (rxLast) begin
                        short_err = 1'b1;
                        state_nxt = ST_HDR;
                    end else begin
                        state_nxt = hdr_ok ? ST_X : ST_DRAIN;
                    end
                end
            end
            ST_X, ST_Y: begin
                if (rxValid) begin
                    if (rxLast) begin
                        short_err = 1'b1;
                        state_nxt = ST_HDR;
                    end else begin
                        state_nxt = (state == ST_X) ? ST_Y : ST_S;
                    end
                end else if (timeout) begin
                    short_err = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_S: begin
                if (rxValid) begin
                    if (rxLast) begin
                        commit    = crc_ok;
                        crc_err   = !crc_ok;
                        state_nxt = ST_HDR;
                    end else begin
                        long_err  = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end else if (timeout) begin
                    short_err = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_DRAIN: begin
                if ((rxValid && rxLast) || timeout) state_nxt = ST_HDR;
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge rxClk or negedge rxAresetn) begin
        if (!rxAresetn) begin
            state      <= ST_HDR;
            idle_cnt   <= '0;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            wrEnable   <= 1'b0;
            wrIndex    <= '0;
            wrX        <= '0;
            wrY        <= '0;
            wrS        <= '0;
            wrClip     <= 1'b0;
            cycleCount <= '0;
        end else begin
            state    <= state_nxt;
            wrEnable <= commit;
            if (rxValid || (state == ST_HDR)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (rxValid) begin
                case (state)
                    ST_HDR:  if (hdr_ok) idx_q <= rxData[FOFB_IDX_WIDTH-1:0];
                    ST_X:    x_q <= rxData;
                    ST_Y:    y_q <= rxData;
                    default: ;
                endcase
            end
            if (commit) begin
                wrIndex <= idx_q;
                wrX     <= x_q;
                wrY     <= y_q;
                wrS     <= rxData[DATA_WIDTH-3:0];
                wrClip  <= rxData[CLIP_BIT];
            end
            // Snapshot the tally before this cycle's commit, which belongs to the new FA cycle.
            if (rxFaStrobe) cycleCount <= tally;
        end
    end

    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_good_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(commit), .clr(1'b0), .value(goodCount)
    );
    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_hdr_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(hdr_err), .clr(1'b0), .value(hdrErrCount)
    );
    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_crc_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(crc_err), .clr(1'b0), .value(crcErrCount)
    );
    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_short_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(short_err), .clr(1'b0), .value(shortErrCount)
    );
    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_long_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(long_err), .clr(1'b0), .value(longErrCount)
    );
    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_tally_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(commit), .clr(rxFaStrobe), .value(tally)
    );

`ifdef CELL_COMM_DECODER_BITMAP_EN
    logic [2**FOFB_IDX_WIDTH-1:0] seen;
    logic                         dup_hit;

    assign dup_hit = commit && !rxFaStrobe && seen[idx_q];

    always_ff @(posedge rxClk or negedge rxAresetn) begin
        if (!rxAresetn) begin
            seen         <= '0;
            rxSeenBitmap <= '0;
        end else begin
            if (rxFaStrobe) begin
                rxSeenBitmap <= seen;
                seen         <= '0;
            end
            if (commit) seen[idx_q] <= 1'b1;
        end
    end

    cell_comm_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_dup_cnt (
        .clk(rxClk), .rst_n(rxAresetn), .inc(dup_hit), .clr(1'b0), .value(dupErrCount)
    );
`endif

endmodule

// File: tb/tb_cell_comm_packet_decoder.sv
// Directed bench for cell_comm_packet_decoder with hand-computed expectations.
module tb_cell_comm_packet_decoder;

    localparam int CW = 11;

    logic          rxClk;
    logic          rxAresetn;
    logic          rxValid;
    logic          rxLast;
    logic [31:0]   rxData;
    logic          rxCRCvalid;
    logic          rxCRCpass;
    logic          rxFaStrobe;
    logic          wrEnable;
    logic [8:0]    wrIndex;
    logic [31:0]   wrX;
    logic [31:0]   wrY;
    logic [29:0]   wrS;
    logic          wrClip;
    logic [CW-1:0] goodCount;
    logic [CW-1:0] hdrErrCount;
    logic [CW-1:0] crcErrCount;
    logic [CW-1:0] shortErrCount;
    logic [CW-1:0] longErrCount;
    logic [CW-1:0] cycleCount;
`ifdef CELL_COMM_DECODER_BITMAP_EN
    logic [511:0]  rxSeenBitmap;
    logic [CW-1:0] dupErrCount;
`endif

    int passed = 0;
    int total  = 0;

    cell_comm_packet_decoder #(
        .DATA_WIDTH(32), .FOFB_IDX_WIDTH(9), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(63)
    ) dut (
        .rxClk(rxClk), .rxAresetn(rxAresetn), .rxValid(rxValid), .rxLast(rxLast),
        .rxData(rxData), .rxCRCvalid(rxCRCvalid), .rxCRCpass(rxCRCpass),
        .rxFaStrobe(rxFaStrobe), .wrEnable(wrEnable), .wrIndex(wrIndex), .wrX(wrX),
        .wrY(wrY), .wrS(wrS), .wrClip(wrClip), .goodCount(goodCount),
        .hdrErrCount(hdrErrCount), .crcErrCount(crcErrCount),
        .shortErrCount(shortErrCount), .longErrCount(longErrCount),
        .cycleCount(cycleCount)
`ifdef CELL_COMM_DECODER_BITMAP_EN
        , .rxSeenBitmap(rxSeenBitmap), .dupErrCount(dupErrCount)
`endif
    );

    initial rxClk = 1'b0;
    always #5 rxClk = ~rxClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic word(input logic [31:0] d, input logic last, input logic crcv = 1'b0,
                        input logic crcp = 1'b0, input logic strobe = 1'b0);
        rxValid    = 1'b1;
        rxData     = d;
        rxLast     = last;
        rxCRCvalid = crcv;
        rxCRCpass  = crcp;
        rxFaStrobe = strobe;
        @(posedge rxClk);
        #1;
        rxFaStrobe = 1'b0;
    endtask

    task automatic idle(input int n, input logic strobe = 1'b0);
        rxValid    = 1'b0;
        rxLast     = 1'b0;
        rxCRCvalid = 1'b0;
        rxCRCpass  = 1'b0;
        for (int k = 0; k < n; k++) begin
            rxFaStrobe = strobe && (k == 0);
            @(posedge rxClk);
            #1;
        end
        rxFaStrobe = 1'b0;
    endtask

    task automatic good_pkt(input logic [8:0] idx, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] s, input logic strobe_on_s = 1'b0);
        word(32'hA5BE_0000 | {23'd0, idx}, 1'b0);
        word(x, 1'b0);
        word(y, 1'b0);
        word(s, 1'b1, 1'b1, 1'b1, strobe_on_s);
    endtask

    task automatic check_write(input string tag, input logic [8:0] idx, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] s);
        check({tag, "_en"}, wrEnable, 1);
        check({tag, "_fields"}, {wrIndex, wrX, wrY, wrS, wrClip}, {idx, x, y, s[29:0], s[30]});
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_wr"}, {wrEnable, wrIndex, wrX, wrY, wrS, wrClip}, 0);
        check({tag, "_cnt"}, {goodCount, hdrErrCount, crcErrCount, shortErrCount,
                              longErrCount, cycleCount}, 0);
    endtask

    logic [31:0] bx;
    logic [31:0] by;
    logic [31:0] bs;
    logic [8:0]  bi;

    initial begin
        rxAresetn  = 1'b0;
        rxValid    = 1'b0;
        rxLast     = 1'b0;
        rxData     = '0;
        rxCRCvalid = 1'b0;
        rxCRCpass  = 1'b0;
        rxFaStrobe = 1'b0;
        #22;
        check_zero_state("reset");
        @(negedge rxClk);
        rxAresetn = 1'b1;
        idle(2);

        // Basic good packet with clip set.
        good_pkt(9'd5, 32'h11, 32'h22, 32'h4000_0033);
        check_write("good1", 9'd5, 32'h11, 32'h22, 32'h4000_0033);
        check("good1_cnt", goodCount, 1);
        idle(1);
        check("good1_pulse", wrEnable, 0);

        // Bad magic drains the rest of the packet.
        word(32'hA5BF_0005, 1'b0);
        word(32'h1, 1'b0);
        word(32'h2, 1'b0);
        word(32'h3, 1'b1, 1'b1, 1'b1);
        check("hdr_nowrite", wrEnable, 0);
        check("hdr_cnt", {hdrErrCount, shortErrCount, goodCount}, {11'd1, 11'd0, 11'd1});
        good_pkt(9'd7, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0000_0099);
        check_write("hdr_next", 9'd7, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0000_0099);
        check("hdr_next_cnt", goodCount, 2);

        // Header with a nonzero bit above the index field.
        word(32'hA5BE_0205, 1'b0);
        word(32'h1, 1'b0);
        word(32'h2, 1'b0);
        word(32'h3, 1'b1, 1'b1, 1'b1);
        check("hdr_hibit", {hdrErrCount, goodCount, wrEnable}, {11'd2, 11'd2, 1'b0});

        // Last on the Y word.
        idle(1);
        word(32'hA5BE_0003, 1'b0);
        word(32'h5, 1'b0);
        word(32'h6, 1'b1);
        check("short_nowrite", wrEnable, 0);
        check("short_cnt", shortErrCount, 1);
        good_pkt(9'd9, 32'hAA, 32'hBB, 32'h0000_00CC);
        check_write("short_next", 9'd9, 32'hAA, 32'hBB, 32'h0000_00CC);

        // CRC failure, then invalid marker with a passing CRC.
        word(32'hA5BE_0004, 1'b0);
        word(32'h1, 1'b0);
        word(32'h2, 1'b0);
        word(32'h0000_0003, 1'b1, 1'b1, 1'b0);
        check("crc_fail", {crcErrCount, wrEnable}, {11'd1, 1'b0});
        good_pkt(9'd4, 32'h1, 32'h2, 32'h8000_0003);
        check("crc_invalid", {crcErrCount, wrEnable}, {11'd2, 1'b0});
        check("crc_good", goodCount, 3);

        // S without last: long packet, drained until last.
        word(32'hA5BE_0006, 1'b0);
        word(32'h1, 1'b0);
        word(32'h2, 1'b0);
        word(32'h3, 1'b0, 1'b1, 1'b1);
        word(32'hA5BE_0006, 1'b0);
        word(32'h4, 1'b1, 1'b1, 1'b1);
        check("long_cnt", {longErrCount, wrEnable, goodCount}, {11'd1, 1'b0, 11'd3});
        good_pkt(9'd511, 32'h7, 32'h8, 32'h3FFF_FFFF);
        check_write("long_next", 9'd511, 32'h7, 32'h8, 32'h3FFF_FFFF);

        // Idle gap inside a packet aborts it.
        word(32'hA5BE_000B, 1'b0);
        word(32'h77, 1'b0);
        idle(70);
        check("timeout_cnt", {shortErrCount, wrEnable}, {11'd2, 1'b0});
        good_pkt(9'd12, 32'h12, 32'h34, 32'h0000_0056);
        check_write("timeout_next", 9'd12, 32'h12, 32'h34, 32'h0000_0056);
        check("timeout_good", goodCount, 5);

        // FA strobe on an idle cycle.
        idle(2, 1'b1);
        check("cycle_pre", cycleCount, 5);

        // Back-to-back packets; strobe at header 400 and coincident with commit 750.
        for (int i = 0; i < 1000; i++) begin
            bi = 9'(i % 512);
            bx = 32'h1000_0000 + 32'(i);
            by = 32'h2000_0000 - 32'(i);
            bs = 32'(i * 7) & 32'h3FFF_FFFF;
            if (i % 2 == 1) bs[30] = 1'b1;
            word(32'hA5BE_0000 | {23'd0, bi}, 1'b0, 1'b0, 1'b0, i == 400);
            if (i > 0) check("bulk_gap", wrEnable, 0);
            if (i == 400) check("cycle_400", cycleCount, 400);
            word(bx, 1'b0);
            word(by, 1'b0);
            word(bs, 1'b1, 1'b1, 1'b1, i == 750);
            check_write("bulk", bi, bx, by, bs);
            if (i == 750) check("cycle_350", cycleCount, 350);
        end
        idle(1, 1'b1);
        check("cycle_250", cycleCount, 250);
        check("bulk_good", goodCount, 1005);
        check("bulk_errs", {hdrErrCount, crcErrCount, shortErrCount, longErrCount},
              {11'd2, 11'd2, 11'd2, 11'd1});

        // Saturation of the short-packet counter.
        for (int i = 0; i < 2044; i++) word(32'hA5BE_0001, 1'b1);
        check("sat_below", shortErrCount, 2046);
        word(32'hA5BE_0001, 1'b1);
        check("sat_full", shortErrCount, 2047);
        for (int i = 0; i < 3; i++) word(32'hA5BE_0001, 1'b1);
        check("sat_hold", shortErrCount, 2047);
        idle(1);

        // Reset in the middle of a packet.
        word(32'hA5BE_0021, 1'b0);
        word(32'h1, 1'b0);
        word(32'h2, 1'b0);
        rxValid = 1'b0;
        #2;
        rxAresetn = 1'b0;
        #1;
        check_zero_state("midreset");
        @(negedge rxClk);
        rxAresetn = 1'b1;
        idle(3);
        check("midreset_nowrite", {wrEnable, goodCount}, 0);
        good_pkt(9'd33, 32'h5A, 32'hA5, 32'h4000_0001);
        check_write("midreset_next", 9'd33, 32'h5A, 32'hA5, 32'h4000_0001);
        check("midreset_good", goodCount, 1);
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cell_comm_packet_decoder.md
Name: cell_comm_packet_decoder

Overview:
- Receive-side consumer of cell-controller packets from the Aurora RX user stream, in the rxClk domain.
- Parses each 4-word packet (header, X, Y, S) and rejects malformed or CRC-failed packets.
- Emits one registered write per good packet into the per-BPM readback table, addressed by the FOFB index.
- Keeps saturating error counters and a per-FA-cycle good-packet tally.

Parameters:
- DATA_WIDTH, 32, stream word width; the header layout requires 32.
- FOFB_IDX_WIDTH, 9, width of the BPM/FOFB index carried in header bits [FOFB_IDX_WIDTH-1:0].
- COUNT_WIDTH, 16, width of each statistics counter.
- TIMEOUT_CYCLES, 63, maximum idle gap inside a packet before it is aborted.

Ports:
- rxClk  in  1  receiver Aurora user clock; the only clock.
- rxAresetn  in  1  asynchronous, active-low reset.
- rxValid  in  1  stream word valid; no back-pressure is possible.
- rxLast  in  1  final word of the packet.
- rxData  in  DATA_WIDTH  stream word.
- rxCRCvalid  in  1  CRC result valid; qualified with rxLast.
- rxCRCpass  in  1  CRC passed; qualified with rxCRCvalid.
- rxFaStrobe  in  1  single-cycle FA-cycle boundary, already in the rxClk domain.
- wrEnable  out  1  one-cycle table write strobe.
- wrIndex  out  FOFB_IDX_WIDTH  table address (FOFB index).
- wrX, wrY  out  DATA_WIDTH  positions.
- wrS  out  DATA_WIDTH-2  sum.
- wrClip  out  1  clipping flag.
- goodCount, hdrErrCount, crcErrCount, shortErrCount, longErrCount  out  COUNT_WIDTH each  saturating counters.
- cycleCount  out  COUNT_WIDTH  good packets seen in the previous FA cycle.

Behaviour:
- Reset: asynchronous, active-low. All outputs and counters go to 0 and the FSM goes to HDR.
- A word is accepted on any cycle with rxValid=1.
- FSM states: HDR, X, Y, S, DRAIN.
- HDR: header is good iff rxData[31:16]==16'hA5BE and rxData[15:FOFB_IDX_WIDTH]==0.
  - Good header: latch index, go to X.
  - Bad header: hdrErrCount++; go to DRAIN, or stay in HDR if rxLast.
  - Header with rxLast (even if good): shortErrCount++, stay in HDR.
- X, Y: latch the word, advance. rxLast here means a short packet: shortErrCount++, go to HDR, no write.
- S with rxLast=1 (commit check):
  - Fails if !rxCRCvalid, !rxCRCpass, or rxData[31]==1 (invalid marker): crcErrCount++, no write.
  - Otherwise goodCount++, and on the next cycle wrEnable=1 for exactly one cycle with wrIndex, wrX, wrY, wrS=rxData[29:0], wrClip=rxData[30].
  - Latency from S acceptance to wrEnable is 1 cycle. Go to HDR.
- S with rxLast=0: longErrCount++, go to DRAIN.
- DRAIN: discard words; on rxLast go to HDR.
- Timeout: in X, Y, S or DRAIN, a 6-bit idle counter (sized to TIMEOUT_CYCLES) reloads on every accepted word.
  - On expiry: go to HDR; shortErrCount++ only if the state was X, Y or S.
- Counters saturate at all-ones and never wrap.
- rxFaStrobe: cycleCount <= running tally, and the tally clears.
  - Same cycle as a goodCount increment: that packet counts in the new cycle (tally <= 1).
- Back-to-back packets with zero idle cycles must decode with no lost words; wrEnable can then assert every 4th cycle.
- Reset asserted mid-packet: the partial packet is discarded and no write is issued.

Optional Feature:
- Macro: CELL_COMM_DECODER_BITMAP_EN.
- Defined: adds output rxSeenBitmap[2**FOFB_IDX_WIDTH-1:0].
  - The bit at wrIndex is set on each good write.
  - rxFaStrobe copies the bitmap to the output register and clears the working copy.
  - Same-cycle write is placed in the cleared copy.
  - Adds output dupErrCount, incremented when a good packet's bit is already set.
- Undefined: no bitmap ports or logic; all other behaviour is identical.

Decomposition:
- Shared package cell_comm_pkg:
  - CELL_COMM_MAGIC = 16'hA5BE.
  - Packet word count of 4.
  - Bit positions: INVALID=31, CLIP=30.
  - FSM state encoding.
- These constants are shared with the TX packet builder.
- Natural sub-module: cell_comm_sat_counter (COUNT_WIDTH, inc, clr, value), instantiated once per counter.

Test Plan:
- Good packet A5BE0005, X=00000011, Y=00000022, S=40000033 (last, CRC ok) -> one cycle later wrEnable=1, wrIndex=5, wrX=0x11, wrY=0x22, wrS=0x33, wrClip=1; goodCount=1.
- Header A5BF0005 then 3 words ending in last -> hdrErrCount=1, no write; next good packet is decoded normally.
- Last asserted on Y word -> shortErrCount=1, no write; a following good packet writes.
- S word with rxCRCpass=0, then a separate good packet whose S has bit31=1 -> crcErrCount=2, goodCount=0.
- 1000 back-to-back good packets at zero gap with rxFaStrobe pulsed mid-run, one strobe coinciding with a commit -> goodCount=1000; cycleCount and new tally split correctly, with the coincident packet counted in the new cycle.
- 70 idle cycles after the X word -> shortErrCount=1, FSM back in HDR; also force a counter to all-ones with one more error -> it stays all-ones.
